// File: rtl/cpu_pkg.sv
// Shared CPU definitions: request-encoder FSM states and the default index width.
package cpu_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    localparam int ID_W_DEF = 3;

endpackage

// File: rtl/priority_encoder_8to3.sv
// Combinational find-first-set: ascending search starting at offset, wrapping
// around, so the first set bit at or after offset wins.
module priority_encoder_8to3
    import cpu_pkg::*;
#(
    parameter int ID_W = ID_W_DEF,
    localparam int N   = 2 ** ID_W
) (
    input  logic [N-1:0]    vec,
    input  logic [ID_W-1:0] offset,
    output logic [ID_W-1:0] index,
    output logic            found
);

    logic [ID_W-1:0] pos;

    // Walk from the far end back toward offset so the nearest hit is written last.
    always_comb begin
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = offset + ID_W'(i);
            if (vec[pos]) begin
                index = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_encoder_8to3.sv
// Sticky 8-to-3 request encoder with valid/ack handshake. Define RR_ARB_EN for
// round-robin selection; otherwise the highest pending index wins.
module irq_encoder_8to3
    import cpu_pkg::*;
#(
    parameter int ID_W = ID_W_DEF,
    localparam int N   = 2 ** ID_W
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic [N-1:0]    iReq,
    input  logic            iAck,
    output logic            oValid,
    output logic [ID_W-1:0] oId,
    output logic [N-1:0]    oPending
);

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    pending;
    logic [N-1:0]    clear;
    logic [N-1:0]    enc_vec;
    logic [ID_W-1:0] enc_offset;
    logic [ID_W-1:0] enc_index;
    logic [ID_W-1:0] sel_id;
    logic            enc_found;
    logic            load;
    logic            accept;

`ifdef RR_ARB_EN
    logic [ID_W-1:0] last_grant;

    assign enc_vec    = pending;
    assign enc_offset = last_grant + ID_W'(1);
    assign sel_id     = enc_index;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            last_grant <= ID_W'(N - 1);
        end else if (accept) begin
            last_grant <= oId;
        end
    end
`else
    // Bit-reversing the vector turns the encoder's lowest-first search into highest-first.
    always_comb begin
        enc_vec = '0;
        for (int i = 0; i < N; i++) begin
            enc_vec[i] = pending[N-1-i];
        end
    end

    assign enc_offset = '0;
    assign sel_id     = ID_W'(N - 1) - enc_index;
`endif

    priority_encoder_8to3 #(
        .ID_W(ID_W)
    ) u_prio (
        .vec   (enc_vec),
        .offset(enc_offset),
        .index (enc_index),
        .found (enc_found)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enc_found) begin
                    load      = 1'b1;
                    state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (iAck) begin
                    accept    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign clear = accept ? (N'(1) << oId) : '0;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= ST_IDLE;
            pending <= '0;
            oId     <= '0;
        end else begin
            state   <= state_nxt;
            pending <= (pending & ~clear) | iReq;
            if (load) begin
                oId <= sel_id;
            end
        end
    end

    assign oValid   = (state == ST_PRESENT);
    assign oPending = pending;

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Randomized and directed bench for irq_encoder_8to3 against a cycle-level reference model.
module tb_irq_encoder_8to3;

    localparam int ID_W = 3;
    localparam int N    = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic            ack;
    logic            valid;
    logic [ID_W-1:0] id;
    logic [N-1:0]    pending;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] m_pend;
    bit           m_valid;
    int           m_id;
    int           m_last;

    always #5 clk = ~clk;

    irq_encoder_8to3 #(.ID_W(ID_W)) dut (
        .iClk    (clk),
        .iRst    (rst),
        .iReq    (req),
        .iAck    (ack),
        .oValid  (valid),
        .oId     (id),
        .oPending(pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] p, input int last);
        int r;
        r = 0;
`ifdef RR_ARB_EN
        for (int k = N; k >= 1; k--) begin
            if (p[(last + k) % N]) r = (last + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (p[k]) r = k;
        end
`endif
        return r;
    endfunction

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input logic [N-1:0] r, input logic a, input logic rs);
        logic [N-1:0] nxt;
        @(negedge clk);
        req = r;
        ack = a;
        rst = rs;
        @(posedge clk);
        if (rs) begin
            m_pend  = '0;
            m_valid = 0;
            m_id    = 0;
            m_last  = N - 1;
        end else begin
            nxt = m_pend;
            if (m_valid && a) begin
                nxt[m_id] = 1'b0;
                m_last    = m_id;
                m_valid   = 0;
            end else if (!m_valid && m_pend != 0) begin
                m_id    = pick(m_pend, m_last);
                m_valid = 1;
            end
            m_pend = nxt | r;
        end
        #1;
        chk("model_valid", 32'(valid), 32'(m_valid));
        chk("model_id", 32'(id), 32'(m_id));
        chk("model_pending", 32'(pending), 32'(m_pend));
    endtask

    initial begin
        req = '0;
        ack = 1'b0;
        rst = 1'b1;
        m_pend = '0; m_valid = 0; m_id = 0; m_last = N - 1;

        // reset then idle
        step(8'h00, 0, 1);
        step(8'h00, 0, 1);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_id", 32'(id), 0);
        chk("rst_pending", 32'(pending), 0);
        step(8'h00, 0, 0);
        chk("idle_valid", 32'(valid), 0);

        // single request
        step(8'h04, 0, 0);
        chk("single_pend", 32'(pending), 32'h04);
        chk("single_novalid", 32'(valid), 0);
        step(8'h00, 1, 0);
        chk("single_valid", 32'(valid), 1);
        chk("single_id", 32'(id), 2);
        chk("single_pend_kept", 32'(pending), 32'h04);
        step(8'h00, 0, 0);
        chk("single_hold", 32'(valid), 1);
        step(8'h00, 1, 0);
        chk("single_acked", 32'(valid), 0);
        chk("single_cleared", 32'(pending), 0);

        // two sources, immediate ack
        step(8'h81, 0, 0);
        chk("two_pend", 32'(pending), 32'h81);
        step(8'h00, 0, 0);
        chk("two_first", 32'(id), 7);
        step(8'h00, 1, 0);
        chk("two_bubble", 32'(valid), 0);
        chk("two_pend1", 32'(pending), 32'h01);
        step(8'h00, 0, 0);
        chk("two_second", 32'(id), 0);
        chk("two_valid2", 32'(valid), 1);
        step(8'h00, 1, 0);
        chk("two_pend0", 32'(pending), 0);

        // held requests from reset: set wins over clear, arbitration order
        step(8'h00, 0, 1);
        step(8'h05, 0, 0);
        step(8'h05, 0, 0);
        for (int g = 0; g < 4; g++) begin
`ifdef RR_ARB_EN
            chk("held_id", 32'(id), (g % 2 == 0) ? 0 : 2);
`else
            chk("held_id", 32'(id), 2);
`endif
            chk("held_valid", 32'(valid), 1);
            step(8'h05, 1, 0);
            chk("held_sticky", 32'(pending), 32'h05);
            step(8'h05, 0, 0);
        end

        // reset mid-grant
        step(8'h00, 0, 1);
        step(8'h20, 0, 0);
        step(8'h00, 0, 0);
        chk("midrst_id", 32'(id), 5);
        step(8'h00, 0, 1);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_pend", 32'(pending), 0);
        for (int c = 0; c < 3; c++) begin
            step(8'h00, 0, 0);
            chk("midrst_nogrant", 32'(valid), 0);
        end

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            step(N'($urandom & $urandom & $urandom), 1'($urandom), ($urandom_range(63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_encoder_8to3.md
# irq_encoder_8to3

Sequential 8-to-3 request encoder for the 16-bit CPU: the encode-side counterpart of the 3-to-8 decoder. It latches up to eight request lines into a sticky pending register, selects one pending source, and presents its 3-bit index to the control unit over a valid/ack handshake. Each request is cleared only on acknowledge. It sits between the peripheral/interrupt request lines and the CPU control FSM.

## Interface
- ID_W, 3, index width; number of sources N = 2**ID_W (8 at default)
- iClk  input  1  clock, all logic on rising edge
- iRst  input  1  reset, synchronous, active-high
- iReq  input  N  request lines, level-sampled every cycle
- iAck  input  1  consumer accepts the presented index
- oValid  output  1  index on oId is valid
- oId  output  ID_W  encoded index of the granted source
- oPending  output  N  current pending register

## Operation
- Pending register: each cycle, pending <= (pending & ~clear) | iReq. The clear mask is one-hot(oId) when iAck && oValid, otherwise 0. Set wins over clear: an acked bit whose iReq is still high stays pending.
- FSM, two states:
  - IDLE: oValid=0. If pending != 0, register the selected index into oId, set oValid=1, go to PRESENT. Otherwise stay.
  - PRESENT: hold oId and oValid stable. Ignore new requests for selection. On iAck, clear pending[oId], drop oValid, go to IDLE.
- Selection in fixed-priority mode: highest set index wins (bit 7 over bit 0).
- Selection only reads the registered pending value. A request arriving in the same cycle as the IDLE decision is not considered until the next cycle.
- iAck while oValid=0 is ignored: no state change, no clear.
- oId is don't-care while oValid=0 but is held at its last value (no toggling).
- Reset values: oValid=0, oId=0, oPending=0, state IDLE, round-robin pointer N-1 (when compiled in).
- Reset during PRESENT abandons the grant: oValid=0 the cycle after, and all pending bits are lost.

## Timing
- iReq[i] sampled at edge k: oPending[i]=1 after edge k, oValid=1 with oId=i after edge k+1. Grant latency is 2 cycles.
- iAck sampled at edge m with oValid=1: oValid=0 and the bit cleared after edge m. The earliest next oValid is after edge m+1, so there is a mandatory one-cycle bubble between grants.
- Back-to-back throughput: one grant per 2 cycles when the consumer acks immediately.
- oValid, oId and oPending are all registered outputs; there is no combinational input-to-output path.

## Configuration
- RR_ARB_EN defined: round-robin selection.
  - A last-grant pointer updates to oId on each accepted ack.
  - Search is ascending from (pointer+1) mod N, wrapping; the first pending bit wins.
  - From reset the search starts at index 0.
- RR_ARB_EN undefined: fixed priority, highest index wins. No pointer register is built.

## Structure
- Shared package cpu_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_PRESENT)
  - the ID_W default constant
- One natural sub-module, priority_encoder_8to3: combinational find-first-set over N bits.
  - Inputs: vector and rotate offset (offset tied to 0 / fixed-priority order when RR_ARB_EN is off).
  - Outputs: index and found flag.
  - Instantiated once by irq_encoder_8to3.

## Test plan
- Reset then idle: iRst=1 for 2 cycles, iReq=0 -> oValid=0, oId=0, oPending=8'h00 throughout.
- Single request: pulse iReq=8'b0000_0100 for one cycle -> oPending=8'h04 next cycle; oValid=1, oId=3'd2 one cycle later; held until iAck=1; then oValid=0 and oPending=8'h00.
- Fixed priority, RR_ARB_EN undefined: iReq=8'b1000_0001 for one cycle, ack each grant immediately -> oId=7 then oId=0, with one idle cycle between; oPending goes 8'h81 -> 8'h01 -> 8'h00.
- Round robin, RR_ARB_EN defined: hold iReq=8'h05, ack every grant -> oId sequence 0, 2, 0, 2.
- Set-wins-over-clear: iAck in the same cycle iReq[oId] is high -> the bit stays set in oPending and the same index is re-granted after the bubble.
- Reset mid-grant: oValid=1 with oId=5, assert iRst one cycle -> oValid=0, oPending=8'h00 next cycle, and no grant follows without new iReq.
